// File: rtl/dffsr_shift_reg_pkg.sv
// Shared mode encodings and sizing helper for the dffsr_shift_reg datapath.
package dffsr_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dffsr_shift_reg_mod_counter.sv
// Modulo-MOD event counter with a registered pulse on the wrapping event.
module mod_counter
    import dffsr_shift_reg_pkg::*;
#(
    parameter int MOD = 8
) (
    input  logic                  C,
    input  logic                  R,
    input  logic                  CLR,
    input  logic                  INC,
    output logic [cnt_w(MOD)-1:0] CNT,
    output logic                  WRAP
);

    localparam int CW = cnt_w(MOD);
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_wrap;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge C) begin
        if (R || CLR) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (INC) begin
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            r_wrap <= w_last;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign CNT  = r_cnt;
    assign WRAP = r_wrap;

endmodule

// File: rtl/dffsr_shift_reg.sv
// Set/reset shift register with hold/shift/load modes, serial out and word-valid pulse.
module dffsr_shift_reg
    import dffsr_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             D,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             WV
);

    mode_e                  w_mode;
    logic                   w_shift;
    logic                   w_inc;
    logic                   w_clr;
    logic [cnt_w(WIDTH)-1:0] w_cnt;
    logic                   w_unused_cnt;
    logic [WIDTH-1:0]       r_q;

    assign w_mode  = mode_e'(MODE);
    assign w_shift = (w_mode == MODE_SHR) || (w_mode == MODE_SHL);
    assign w_inc   = !S && EN && w_shift;
    assign w_clr   = S || (EN && (w_mode == MODE_LOAD));

    always_ff @(posedge C) begin
        if (R) begin
            r_q <= RST_VAL;
        end else if (S) begin
            r_q <= '1;
        end else if (EN) begin
            case (w_mode)
                MODE_SHR:  r_q <= {D, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], D};
                MODE_LOAD: r_q <= P;
                default:   r_q <= r_q;
            endcase
        end
    end

    // WV is the counter's registered wrap pulse; the count itself is internal only.
    mod_counter #(.MOD(WIDTH)) u_cnt (
        .C    (C),
        .R    (R),
        .CLR  (w_clr),
        .INC  (w_inc),
        .CNT  (w_cnt),
        .WRAP (WV)
    );

    assign w_unused_cnt = ^w_cnt;

    assign Q  = r_q;
    assign SO = (w_mode == MODE_SHL) ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: tb/tb_dffsr_shift_reg.sv
// Directed table-driven bench for dffsr_shift_reg (WIDTH=8) plus a WIDTH=10 sequence.
module tb_dffsr_shift_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       r, s, en, d;
    logic [1:0] mode;
    logic [7:0] p, q;
    logic       so, wv;

    logic       r2, s2, en2, d2;
    logic [1:0] mode2;
    logic [9:0] p2, q2;
    logic       so2, wv2;

    int total = 0;
    int bad   = 0;

    dffsr_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .C(clk), .R(r), .S(s), .EN(en), .MODE(mode), .D(d), .P(p),
        .Q(q), .SO(so), .WV(wv)
    );

    dffsr_shift_reg #(.WIDTH(10), .RST_VAL(10'h155)) dut10 (
        .C(clk), .R(r2), .S(s2), .EN(en2), .MODE(mode2), .D(d2), .P(p2),
        .Q(q2), .SO(so2), .WV(wv2)
    );

    typedef struct {
        logic       r, s, en;
        logic [1:0] mode;
        logic       d;
        logic [7:0] p;
        logic       chk_so, so;
        logic [7:0] q;
        logic       wv;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic vr, vs, ven, input logic [1:0] vm,
                                input logic vd, input logic [7:0] vp,
                                input logic vc, vso, input logic [7:0] vq,
                                input logic vwv);
        vec_t v;
        v = '{vr, vs, ven, vm, vd, vp, vc, vso, vq, vwv};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic shr8(input logic vd, input logic vso, input logic [7:0] vq,
                        input logic vwv);
        add(0, 0, 1, 2'b01, vd, 8'h00, 1, vso, vq, vwv);
    endtask

    task automatic shl8(input logic vd, input logic vso, input logic [7:0] vq,
                        input logic vwv);
        add(0, 0, 1, 2'b10, vd, 8'h00, 1, vso, vq, vwv);
    endtask

    logic [9:0] m2;

    initial begin
        r = 1; s = 1; en = 1; mode = 2'b00; d = 0; p = 8'h00;
        r2 = 1; s2 = 0; en2 = 1; mode2 = 2'b00; d2 = 0; p2 = '0;

        // R and S together, then S alone, then load A5 and shift it out
        add(1, 1, 1, 2'b00, 0, 8'h00, 0, 0, 8'h00, 0);
        add(1, 1, 1, 2'b00, 0, 8'h00, 1, 0, 8'h00, 0);
        add(0, 1, 1, 2'b00, 0, 8'h00, 1, 0, 8'hFF, 0);
        add(0, 0, 1, 2'b11, 0, 8'hA5, 1, 1, 8'hA5, 0);
        shr8(0, 1, 8'h52, 0); shr8(0, 0, 8'h29, 0); shr8(0, 1, 8'h14, 0); shr8(0, 0, 8'h0A, 0);
        shr8(0, 0, 8'h05, 0); shr8(0, 1, 8'h02, 0); shr8(0, 0, 8'h01, 0); shr8(0, 1, 8'h00, 1);
        // LSB-first deserialise 0x96
        shr8(0, 0, 8'h00, 0); shr8(1, 0, 8'h80, 0); shr8(1, 0, 8'hC0, 0); shr8(0, 0, 8'h60, 0);
        shr8(1, 0, 8'hB0, 0); shr8(0, 0, 8'h58, 0); shr8(0, 0, 8'h2C, 0); shr8(1, 0, 8'h96, 1);
        // Back-to-back word
        shr8(1, 0, 8'hCB, 0); shr8(1, 1, 8'hE5, 0); shr8(1, 1, 8'hF2, 0); shr8(1, 0, 8'hF9, 0);
        shr8(1, 1, 8'hFC, 0); shr8(1, 0, 8'hFE, 0); shr8(1, 0, 8'hFF, 0); shr8(1, 1, 8'hFF, 1);
        // 3 shifts, stall 5 with EN=0 and 1 with MODE=00, 5 more shifts
        shr8(0, 1, 8'h7F, 0); shr8(0, 1, 8'h3F, 0); shr8(0, 1, 8'h1F, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 2'b01, 0, 8'h00, 1, 1, 8'h1F, 0);
        add(0, 0, 1, 2'b00, 0, 8'h00, 1, 1, 8'h1F, 0);
        shr8(0, 1, 8'h0F, 0); shr8(0, 1, 8'h07, 0); shr8(0, 1, 8'h03, 0); shr8(0, 1, 8'h01, 0);
        shr8(0, 1, 8'h00, 1);
        // Load 81, shift left with D=1
        add(0, 0, 1, 2'b11, 0, 8'h81, 1, 0, 8'h81, 0);
        shl8(1, 1, 8'h03, 0);
        // 5 more shifts (6 in word), then reset aborts the word
        shr8(1, 1, 8'h81, 0); shr8(1, 1, 8'hC0, 0); shr8(1, 0, 8'hE0, 0); shr8(1, 0, 8'hF0, 0);
        shr8(1, 0, 8'hF8, 0);
        add(1, 0, 1, 2'b01, 0, 8'h00, 1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) shr8(0, 0, 8'h00, 0);
        shr8(0, 0, 8'h00, 1);
        // S mid-word aborts, then a full word of left shifts
        shr8(0, 0, 8'h00, 0); shr8(0, 0, 8'h00, 0); shr8(0, 0, 8'h00, 0);
        add(0, 1, 1, 2'b00, 0, 8'h00, 1, 0, 8'hFF, 0);
        shl8(0, 1, 8'hFE, 0); shl8(0, 1, 8'hFC, 0); shl8(0, 1, 8'hF8, 0); shl8(0, 1, 8'hF0, 0);
        shl8(0, 1, 8'hE0, 0); shl8(0, 1, 8'hC0, 0); shl8(0, 1, 8'h80, 0); shl8(0, 1, 8'h00, 1);
        // Mixed directions share one count
        shr8(1, 0, 8'h80, 0); shr8(1, 0, 8'hC0, 0); shr8(1, 0, 8'hE0, 0); shr8(1, 0, 8'hF0, 0);
        shl8(0, 1, 8'hE0, 0); shl8(0, 1, 8'hC0, 0); shl8(0, 1, 8'h80, 0); shl8(0, 1, 8'h00, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i].r; s = tbl[i].s; en = tbl[i].en; mode = tbl[i].mode;
            d = tbl[i].d; p = tbl[i].p;
            #1;
            if (tbl[i].chk_so) chk("so", i, {15'd0, so}, {15'd0, tbl[i].so});
            @(posedge clk); #1;
            chk("q", i, {8'd0, q}, {8'd0, tbl[i].q});
            chk("wv", i, {15'd0, wv}, {15'd0, tbl[i].wv});
            if (i == 0) r2 = 0;
        end

        // WIDTH=10, RST_VAL=0x155: reset value, mid-word reset, wrap at 9
        r = 0; s = 0; en = 0; mode = 2'b00;
        r2 = 1; mode2 = 2'b01; d2 = 0;
        @(posedge clk); #1;
        m2 = 10'h155;
        chk("w10_rst_q", 0, {6'd0, q2}, {6'd0, m2});
        chk("w10_rst_wv", 0, {15'd0, wv2}, 16'd0);
        chk("w10_rst_so", 0, {15'd0, so2}, 16'd1);
        r2 = 0;
        for (int i = 0; i < 6; i++) begin
            d2 = 1'(i);
            @(posedge clk); #1;
            m2 = {d2, m2[9:1]};
            chk("w10_pre_q", i, {6'd0, q2}, {6'd0, m2});
            chk("w10_pre_wv", i, {15'd0, wv2}, 16'd0);
        end
        r2 = 1;
        @(posedge clk); #1;
        m2 = 10'h155;
        chk("w10_midrst_q", 0, {6'd0, q2}, {6'd0, m2});
        r2 = 0;
        for (int i = 0; i < 20; i++) begin
            d2 = 1'((i * 7 + 3) % 5 == 0);
            #1;
            chk("w10_so", i, {15'd0, so2}, {15'd0, m2[0]});
            @(posedge clk); #1;
            m2 = {d2, m2[9:1]};
            chk("w10_q", i, {6'd0, q2}, {6'd0, m2});
            chk("w10_wv", i, {15'd0, wv2}, {15'd0, (i == 9 || i == 19)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
